mtr_ramp: RTL

MTR_RAMP -- requirements
Module: mtr_ramp

---
 rtl/mtr_ramp_pkg.sv | 17 +
 rtl/mtr_ramp_axis.sv | 94 +++++++++
 rtl/mtr_ramp.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mtr_ramp_pkg.sv
// rtl/mtr_ramp_pkg.sv - shared widths, command/difference types and state enum for mtr_ramp
package mtr_ramp_pkg;

    localparam int MTR_W = 11;

    typedef logic signed [MTR_W-1:0] cmd_t;
    // One bit wider than a command so that 1023 - (-1024) cannot overflow.
    typedef logic signed [MTR_W:0]   diff_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } state_t;

endpackage

// File: rtl/mtr_ramp_axis.sv
// rtl/mtr_ramp_axis.sv - one side: target capture, rate-limited step, zero-cross dwell under MTR_RAMP_ZERO_CROSS_EN
module mtr_ramp_axis
    import mtr_ramp_pkg::*;
#(
    parameter int STEP = 8
`ifdef MTR_RAMP_ZERO_CROSS_EN
    , parameter int DWELL = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    en,
    input  logic                    tgt_vld,
    input  logic signed [MTR_W-1:0] new_tgt,
    output logic signed [MTR_W-1:0] cmd,
    output logic                    settled
);

    cmd_t  tgt;
    cmd_t  eff;
    diff_t cmd_x;
    diff_t eff_x;
    diff_t diff;
    diff_t nxt;

    assign eff   = en ? tgt : '0;
    assign cmd_x = {cmd[MTR_W-1], cmd};
    assign eff_x = {eff[MTR_W-1], eff};

    always_comb begin
        diff = eff_x - cmd_x;
        nxt  = eff_x;
        if (diff > diff_t'(STEP)) begin
            nxt = cmd_x + diff_t'(STEP);
        end else if (diff < -diff_t'(STEP)) begin
            nxt = cmd_x - diff_t'(STEP);
        end
    end

    // A tick on the capture edge still steps toward the old target.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt <= '0;
        end else if (tgt_vld) begin
            tgt <= new_tgt;
        end
    end

`ifdef MTR_RAMP_ZERO_CROSS_EN
    localparam int DW_W = $clog2(DWELL + 2);

    logic [DW_W-1:0] dwell;
    logic            cross;

    // Reaching or passing zero on the way to an opposite-sign target parks the output at zero.
    assign cross = ((cmd > 0) && (nxt <= 0) && (eff < 0)) ||
                   ((cmd < 0) && (nxt >= 0) && (eff > 0));

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd   <= '0;
            dwell <= '0;
        end else begin
            if (tick) begin
                if (dwell != '0) begin
                    dwell <= dwell - 1'b1;
                end else if (cross) begin
                    cmd   <= '0;
                    dwell <= DW_W'(DWELL);
                end else begin
                    cmd <= cmd_t'(nxt);
                end
            end
            if (eff == '0) begin
                dwell <= '0;
            end
        end
    end

    assign settled = (cmd == eff) && (dwell == '0);
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd <= '0;
        end else if (tick) begin
            cmd <= cmd_t'(nxt);
        end
    end

    assign settled = (cmd == eff);
`endif

endmodule

// File: rtl/mtr_ramp.sv
// rtl/mtr_ramp.sv - dual motor command ramp: tick divider, en handling, state machine (option MTR_RAMP_ZERO_CROSS_EN)
module mtr_ramp
    import mtr_ramp_pkg::*;
#(
    parameter int STEP  = 8,
    parameter int DIV   = 64,
    parameter int DWELL = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    tgt_vld,
    input  logic signed [MTR_W-1:0] lft_tgt,
    input  logic signed [MTR_W-1:0] rht_tgt,
    output logic signed [MTR_W-1:0] lft,
    output logic signed [MTR_W-1:0] rht,
    output logic                    at_tgt,
    output logic                    busy
);

    localparam int CW = $clog2(DIV);

    if (STEP < 1 || STEP > 255 || DIV < 2 || DIV > 4096 || DWELL < 0) begin : g_bad_param
        $error("mtr_ramp: parameter out of range");
    end

    logic [CW-1:0] cnt;
    logic          tick;
    logic          lft_ok;
    logic          rht_ok;
    logic          settled;
    logic          zero;
    state_t        state;
    state_t        state_nxt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    mtr_ramp_axis #(
        .STEP    (STEP)
`ifdef MTR_RAMP_ZERO_CROSS_EN
        , .DWELL (DWELL)
`endif
    ) u_lft (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .en      (en),
        .tgt_vld (tgt_vld),
        .new_tgt (lft_tgt),
        .cmd     (lft),
        .settled (lft_ok)
    );

    mtr_ramp_axis #(
        .STEP    (STEP)
`ifdef MTR_RAMP_ZERO_CROSS_EN
        , .DWELL (DWELL)
`endif
    ) u_rht (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .en      (en),
        .tgt_vld (tgt_vld),
        .new_tgt (rht_tgt),
        .cmd     (rht),
        .settled (rht_ok)
    );

    assign settled = lft_ok && rht_ok;
    assign zero    = (lft == '0) && (rht == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = settled ? HOLD : RAMP;
                end
            end
            RAMP: begin
                if (!en) begin
                    state_nxt = zero ? IDLE : STOP;
                end else if (settled) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!en) begin
                    state_nxt = zero ? IDLE : STOP;
                end else if (!settled) begin
                    state_nxt = RAMP;
                end
            end
            STOP: begin
                if (en) begin
                    state_nxt = RAMP;
                end else if (zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status follows the registered state, one clock behind the outputs.
    assign at_tgt = (state == HOLD);
    assign busy   = (state == RAMP) || (state == STOP);

endmodule
